// File: rtl/uart_alu_if.sv
// UART pin pair between the host and the ALU.
// master = host side, slave = ALU side.
interface uart_alu_if;
  logic rxd_i;
  logic txd_o;

  modport master (output rxd_i, input txd_o);
  modport slave  (input rxd_i, output txd_o);
endinterface

// File: rtl/uart_alu.sv
// 8N1 UART front end feeding a 32-bit add/mul/div reducer.
// Each packet holds: opcode, reserved byte, 16-bit count N, then N little-endian 32-bit operands.
module uart_alu #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  uart_alu_if.slave uart
);
  // state     | meaning
  // S_IDLE    | clear packet context
  // S_OPCODE  | wait for opcode byte
  // S_RSVD    | wait for reserved byte
  // S_LEN_LO  | wait for N[7:0]
  // S_LEN_HI  | wait for N[15:8], preload identity
  // S_OPERAND | collect 4 operand bytes
  // S_EXEC    | apply operand to accumulator
  // S_RESP    | send 4 result bytes
  localparam int unsigned BIT_CYC = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [15:0] BIT_M1  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_M1 = 16'(BIT_CYC / 2 - 1);
  localparam logic [7:0]  OP_ADD  = 8'h10;
  localparam logic [7:0]  OP_MUL  = 8'h11;
  localparam logic [7:0]  OP_DIV  = 8'h12;

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_EXEC, S_RESP
  } state_t;
  state_t state, state_nx;

  logic        rx_s1, rx_s2, rx_prev, rx_busy, rx_valid;
  logic [3:0]  rx_idx;
  logic [15:0] rx_tmr;
  logic [7:0]  rx_sh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_idx   <= '0;
      rx_tmr   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= uart.rxd_i;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_tmr  <= HALF_M1;
          rx_idx  <= '0;
        end
      end else if (rx_tmr != '0) begin
        rx_tmr <= rx_tmr - 16'd1;
      end else begin
        rx_tmr <= BIT_M1;
        rx_idx <= rx_idx + 4'd1;
        // a start bit that is high again at mid-bit was only a glitch
        if (rx_idx == 4'd0) rx_busy <= ~rx_s2;
        else if (rx_idx <= 4'd8) rx_sh <= {rx_s2, rx_sh[7:1]};
        else begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_s2;
        end
      end
    end
  end

  logic        tx_go, tx_busy, tx_line;
  logic [7:0]  tx_data;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_idx;
  logic [15:0] tx_tmr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_sh   <= '1;
      tx_idx  <= '0;
      tx_tmr  <= '0;
    end else if (!tx_busy) begin
      if (tx_go) begin
        tx_busy <= 1'b1;
        tx_line <= 1'b0;
        tx_sh   <= {1'b1, tx_data};
        tx_idx  <= '0;
        tx_tmr  <= BIT_M1;
      end
    end else if (tx_tmr != '0) begin
      tx_tmr <= tx_tmr - 16'd1;
    end else if (tx_idx == 4'd9) begin
      tx_busy <= 1'b0;
    end else begin
      tx_line <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[8:1]};
      tx_idx  <= tx_idx + 4'd1;
      tx_tmr  <= BIT_M1;
    end
  end

  assign uart.txd_o = tx_line;

  logic [7:0]  opcode, len_lo;
  logic [15:0] ops_left, len_full;
  logic [1:0]  byte_cnt;
  logic [2:0]  resp_cnt;
  logic [31:0] op_buf, acc, div_q, div_r, rem_diff, alu_simple;
  logic [32:0] rem_sh;
  logic [5:0]  div_cnt;
  logic        sticky, first, div_run, div_ge, known, need_div, exec_done;

  assign known     = (opcode == OP_ADD) || (opcode == OP_MUL) || (opcode == OP_DIV);
  assign len_full  = {rx_sh, len_lo};
  assign rem_sh    = {div_r, div_q[31]};
  assign div_ge    = rem_sh >= {1'b0, op_buf};
  assign rem_diff  = rem_sh[31:0] - op_buf;
  assign need_div  = (opcode == OP_DIV) && !first && !sticky && (op_buf != '0);
  assign exec_done = (state == S_EXEC) && (div_run ? (div_cnt == 6'd1) : !need_div);

  // DIV only lands here on a zero divisor or once the zero flag is already sticky
  always_comb begin
    alu_simple = acc;
    if (first) alu_simple = op_buf;
    else begin
      case (opcode)
        OP_ADD:  alu_simple = acc + op_buf;
        OP_MUL:  alu_simple = acc * op_buf;
        OP_DIV:  alu_simple = 32'hFFFF_FFFF;
        default: alu_simple = acc;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_go    = 1'b0;
    tx_data  = acc[{resp_cnt[1:0], 3'b000} +: 8];
    case (state)
      S_IDLE:    state_nx = S_OPCODE;
      S_OPCODE:  if (rx_valid) state_nx = S_RSVD;
      S_RSVD:    if (rx_valid) state_nx = S_LEN_LO;
      S_LEN_LO:  if (rx_valid) state_nx = S_LEN_HI;
      S_LEN_HI:  if (rx_valid) state_nx = (len_full != '0) ? S_OPERAND : (known ? S_RESP : S_IDLE);
      S_OPERAND: if (rx_valid && byte_cnt == 2'd3) state_nx = S_EXEC;
      S_EXEC:    if (exec_done) state_nx = (ops_left != 16'd1) ? S_OPERAND : (known ? S_RESP : S_IDLE);
      S_RESP: begin
        if (resp_cnt[2]) begin
          if (!tx_busy) state_nx = S_IDLE;
        end else if (!tx_busy) tx_go = 1'b1;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode <= '0;  len_lo <= '0;  ops_left <= '0;  byte_cnt <= '0;
      resp_cnt <= '0;  op_buf <= '0;  acc <= '0;  sticky <= 1'b0;
      first <= 1'b0;  div_run <= 1'b0;  div_cnt <= '0;  div_q <= '0;  div_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sticky   <= 1'b0;
          resp_cnt <= '0;
          byte_cnt <= '0;
          div_run  <= 1'b0;
          acc      <= '0;
        end
        S_OPCODE: if (rx_valid) opcode <= rx_sh;
        S_LEN_LO: if (rx_valid) len_lo <= rx_sh;
        S_LEN_HI: if (rx_valid) begin
          ops_left <= len_full;
          first    <= 1'b1;
          acc      <= (opcode == OP_MUL) ? 32'd1 : 32'd0;
        end
        S_OPERAND: if (rx_valid) begin
          op_buf   <= {rx_sh, op_buf[31:8]};
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_EXEC: begin
          if (div_run) begin
            div_cnt <= div_cnt - 6'd1;
            div_r   <= div_ge ? rem_diff : rem_sh[31:0];
            div_q   <= {div_q[30:0], div_ge};
            if (div_cnt == 6'd1) begin
              div_run <= 1'b0;
              acc     <= {div_q[30:0], div_ge};
            end
          end else if (need_div) begin
            div_run <= 1'b1;
            div_cnt <= 6'd32;
            div_q   <= acc;
            div_r   <= '0;
          end else begin
            acc <= alu_simple;
            if (opcode == OP_DIV && !first) sticky <= 1'b1;
          end
          if (exec_done) begin
            first    <= 1'b0;
            ops_left <= ops_left - 16'd1;
          end
        end
        S_RESP: if (tx_go) resp_cnt <= resp_cnt + 3'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu.sv
// Drives UART command packets into uart_alu and checks each response against a plain arithmetic model.
// A short bit period keeps the run small; it still leaves the divider time between operands.
module tb_uart_alu;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned CLK_HZ = BAUD * 4;
  localparam int          BIT    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_alu_if bus();

  uart_alu #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .uart  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int framing_err = 0;
  logic [7:0]  rx_q[$];
  logic [31:0] ops_q[$];
  logic [7:0]  mon_b;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // host-side receiver on txd_o
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.txd_o === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = bus.txd_o;
        end
        repeat (BIT) @(negedge clk);
        if (bus.txd_o === 1'b1) rx_q.push_back(mon_b);
        else framing_err++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxd_i = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_hdr(input logic [7:0] opc, input logic [15:0] n);
    send_byte(opc);
    send_byte(8'($urandom));
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  function automatic logic [31:0] model(input logic [7:0] opc);
    logic [31:0] a;
    int dz;
    dz = 0;
    if (ops_q.size() == 0) return (opc == 8'h11) ? 32'd1 : 32'd0;
    a = ops_q[0];
    for (int i = 1; i < ops_q.size(); i++) begin
      if (opc == 8'h10) a = a + ops_q[i];
      else if (opc == 8'h11) a = a * ops_q[i];
      else if (dz != 0 || ops_q[i] == 32'd0) begin
        dz = 1;
        a = 32'hFFFF_FFFF;
      end else a = a / ops_q[i];
    end
    return a;
  endfunction

  task automatic run_pkt(input string tag, input logic [7:0] opc, input logic [31:0] exp, input bit has_resp);
    logic [15:0] n;
    logic [31:0] w, got;
    int cyc;
    n = 16'(ops_q.size());
    rx_q.delete();
    send_hdr(opc, n);
    foreach (ops_q[i]) begin
      w = ops_q[i];
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
    end
    cyc = 0;
    if (has_resp) begin
      while (rx_q.size() < 4 && cyc < 200 * BIT) begin
        @(negedge clk);
        cyc++;
      end
    end else repeat (60 * BIT) @(negedge clk);
    repeat (12 * BIT) @(negedge clk);
    check_val({tag, "_nbytes"}, 32'(rx_q.size()), has_resp ? 32'd4 : 32'd0);
    if (has_resp) begin
      got = '0;
      for (int i = 0; i < 4 && i < rx_q.size(); i++) got[8*i +: 8] = rx_q[i];
      check_val(tag, got, exp);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rxd_i = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_txd", 32'(bus.txd_o), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("idle_txd", 32'(bus.txd_o), 32'd1);

    ops_q = '{32'd1, 32'd2};             run_pkt("add_1_2", 8'h10, 32'd3, 1'b1);
    ops_q = '{32'd3, 32'd4};             run_pkt("add_3_4", 8'h10, 32'd7, 1'b1);
    ops_q = '{32'd5, 32'd6};             run_pkt("mul_5_6", 8'h11, 32'd30, 1'b1);
    ops_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    run_pkt("mul_5ops", 8'h11, 32'd120, 1'b1);
    ops_q = '{32'd4, 32'd2};             run_pkt("div_4_2", 8'h12, 32'd2, 1'b1);
    ops_q = '{32'd64, 32'd8};            run_pkt("div_64_8", 8'h12, 32'd8, 1'b1);
    ops_q = '{32'd7, 32'd0};             run_pkt("div_by0", 8'h12, 32'hFFFF_FFFF, 1'b1);
    ops_q = '{32'd100, 32'd0, 32'd5};    run_pkt("div_sticky", 8'h12, 32'hFFFF_FFFF, 1'b1);
    ops_q = '{32'hFFFF_FFFF, 32'd2};     run_pkt("add_wrap", 8'h10, 32'd1, 1'b1);
    ops_q.delete();                      run_pkt("add_n0", 8'h10, 32'd0, 1'b1);
    ops_q.delete();                      run_pkt("mul_n0", 8'h11, 32'd1, 1'b1);
    ops_q.delete();                      run_pkt("div_n0", 8'h12, 32'd0, 1'b1);
    ops_q = '{32'hDEAD_BEEF};            run_pkt("mul_n1", 8'h11, 32'hDEAD_BEEF, 1'b1);

    for (int k = 0; k < 33; k++) begin
      logic [7:0] opc;
      int n;
      opc = (k < 11) ? 8'h10 : (k < 22) ? 8'h11 : 8'h12;
      n = (opc == 8'h12) ? int'($urandom_range(2, 4)) : int'($urandom_range(2, 15));
      ops_q.delete();
      for (int i = 0; i < n; i++) begin
        if (opc != 8'h12) ops_q.push_back($urandom);
        else if (i > 0 && $urandom_range(0, 5) == 0) ops_q.push_back(32'd0);
        else ops_q.push_back({20'd0, 12'($urandom)});
      end
      run_pkt($sformatf("fuzz%0d", k), opc, model(opc), 1'b1);
    end

    rx_q.delete();
    send_hdr(8'h10, 16'd2);
    for (int j = 0; j < 4; j++) send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst_n = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * BIT) @(negedge clk);
    check_val("rst_mid_quiet", 32'(rx_q.size()), 32'd0);
    ops_q = '{32'd1, 32'd2};             run_pkt("add_after_rst", 8'h10, 32'd3, 1'b1);

    ops_q = '{$urandom, $urandom};       run_pkt("unknown_op", 8'h55, 32'd0, 1'b0);
    ops_q = '{32'd3, 32'd4};             run_pkt("add_after_unk", 8'h10, 32'd7, 1'b1);

    check_val("framing", 32'(framing_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
